// File: rtl/operand_bram_loader_pkg.sv
// Shared encodings for the operand BRAM loader.
// The reader side and any status logic decode operand_sel with these constants.
package operand_bram_loader_pkg;

    // Operand awaiting entry, as presented on operand_sel
    localparam logic [1:0] OP_A    = 2'd0;
    localparam logic [1:0] OP_B    = 2'd1;
    localparam logic [1:0] OP_C    = 2'd2;
    localparam logic [1:0] OP_NONE = 2'd3;

    // Loader FSM states
    localparam logic [2:0] ST_WAIT_A = 3'd0;
    localparam logic [2:0] ST_WAIT_B = 3'd1;
    localparam logic [2:0] ST_WAIT_C = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Operand shown to the operator for a given state; during WRITE the
    // operand just captured stays visible until the next WAIT state.
    function automatic logic [1:0] state_to_sel(input logic [2:0] state,
                                                input logic [1:0] target);
        logic [1:0] sel;
        sel = OP_NONE;
        case (state)
            ST_WAIT_A: sel = OP_A;
            ST_WAIT_B: sel = OP_B;
            ST_WAIT_C: sel = OP_C;
            ST_WRITE:  sel = target;
            default:   sel = OP_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/operand_bram_loader_debouncer.sv
// Button conditioning: 2-FF synchronizer, stability counter and a one-cycle
// pulse on the accepted rising edge. Release edges update the internal level
// but produce no pulse.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock_100Mhz,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             btn_level;
    logic [CNT_W-1:0] stable_cnt;

    // Two-flop synchronizer for the raw asynchronous button
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive cycles of disagreement
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            stable_cnt <= '0;
            btn_level  <= 1'b0;
            btn_pulse  <= 1'b0;
        end else begin
            btn_pulse <= 1'b0;
            if (sync_p1 == btn_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                stable_cnt <= '0;
                btn_level  <= sync_p1;
                btn_pulse  <= sync_p1;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_bram_loader.sv
// Writer side of the A/B/C operand BRAMs. Each accepted load press writes the
// switch value into the next operand (A, B, C) at the current address; after
// DEPTH complete rows the loader parks in DONE with the address back at zero
// so the reader can start. A clear press restarts entry from A[0] without
// erasing what was already written. DEPTH must not exceed 2**ADDR_W.
module operand_bram_loader
    import operand_bram_loader_pkg::*;
#(
    parameter int DATA_W          = 18,
    parameter int ADDR_W          = 3,
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clock_100Mhz,
    input  logic              reset,
    input  logic [15:0]       sw,
    input  logic              btn_load,
    input  logic              btn_clear,
    output logic              ena,
    output logic              wea_a,
    output logic              wea_b,
    output logic              wea_c,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic [1:0]        operand_sel,
    output logic              loading,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    logic        load_pulse;
    logic        clear_pulse;
    logic [15:0] sw_p0;
    logic [15:0] sw_p1;
    logic [2:0]  state;
    logic [1:0]  target;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_debouncer (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .btn_raw     (btn_load),
        .btn_pulse   (load_pulse)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_debouncer (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .btn_raw     (btn_clear),
        .btn_pulse   (clear_pulse)
    );

    // Switch synchronizer; switches are sampled only on a load pulse, long after settling
    always_ff @(posedge clock_100Mhz) begin
        sw_p0 <= sw;
        sw_p1 <= sw_p0;
    end

    // Loader FSM: one strobe per accepted press, address advances after C
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state  <= ST_WAIT_A;
            target <= OP_A;
            addra  <= '0;
            dina   <= '0;
            wea_a  <= 1'b0;
            wea_b  <= 1'b0;
            wea_c  <= 1'b0;
        end else begin
            wea_a <= 1'b0;
            wea_b <= 1'b0;
            wea_c <= 1'b0;
            if (clear_pulse) begin
                // Clear outranks a coincident load: nothing is written
                state  <= ST_WAIT_A;
                target <= OP_A;
                addra  <= '0;
                dina   <= '0;
            end else begin
                case (state)
                    ST_WAIT_A: begin
                        if (load_pulse) begin
                            dina   <= DATA_W'(sw_p1);
                            wea_a  <= 1'b1;
                            target <= OP_A;
                            state  <= ST_WRITE;
                        end
                    end
                    ST_WAIT_B: begin
                        if (load_pulse) begin
                            dina   <= DATA_W'(sw_p1);
                            wea_b  <= 1'b1;
                            target <= OP_B;
                            state  <= ST_WRITE;
                        end
                    end
                    ST_WAIT_C: begin
                        if (load_pulse) begin
                            dina   <= DATA_W'(sw_p1);
                            wea_c  <= 1'b1;
                            target <= OP_C;
                            state  <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        // Any load pulse arriving here is dropped
                        case (target)
                            OP_A:    state <= ST_WAIT_B;
                            OP_B:    state <= ST_WAIT_C;
                            default: begin
                                if (addra == ADDR_LAST) begin
                                    addra <= '0;
                                    state <= ST_DONE;
                                end else begin
                                    addra <= addra + 1'b1;
                                    state <= ST_WAIT_A;
                                end
                            end
                        endcase
                    end
                    ST_DONE: begin
                        // Table complete; load presses are ignored until clear
                    end
                    default: begin
                        state <= ST_WAIT_A;
                    end
                endcase
            end
        end
    end

    // Status decode from the FSM state
    always_comb begin
        ena         = 1'b1;
        done        = (state == ST_DONE);
        loading     = (state != ST_DONE);
        operand_sel = state_to_sel(state, target);
    end

endmodule

// File: tb/tb_operand_bram_loader.sv
// Scoreboard bench for operand_bram_loader with a short debounce and two-row table.
module tb_operand_bram_loader;
    import operand_bram_loader_pkg::*;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2;
    localparam int DEB    = 4;
    localparam int HOLD   = DEB + 8;

    typedef struct packed {
        logic [1:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clock_100Mhz = 1'b0;
    logic              reset        = 1'b1;
    logic [15:0]       sw           = 16'h0;
    logic              btn_load     = 1'b0;
    logic              btn_clear    = 1'b0;
    logic              ena;
    logic              wea_a;
    logic              wea_b;
    logic              wea_c;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [1:0]        operand_sel;
    logic              loading;
    logic              done;

    wr_t  sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_strobes = 0;
    logic [2:0] mon_w;
    logic [2:0] prev_w = 3'b000;
    logic [2:0] exp_w;
    wr_t  mon_e;

    operand_bram_loader #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .DEPTH          (DEPTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .sw          (sw),
        .btn_load    (btn_load),
        .btn_clear   (btn_clear),
        .ena         (ena),
        .wea_a       (wea_a),
        .wea_b       (wea_b),
        .wea_c       (wea_c),
        .addra       (addra),
        .dina        (dina),
        .operand_sel (operand_sel),
        .loading     (loading),
        .done        (done)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock_100Mhz);
    endtask

    task automatic expect_wr(input logic [1:0] sel, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
        wr_t e;
        e.sel  = sel;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    // Clean press of the selected buttons, held long enough to be accepted, then released
    task automatic press(input logic ld, input logic clr, input logic [15:0] v);
        @(negedge clock_100Mhz);
        sw        = v;
        btn_load  = ld;
        btn_clear = clr;
        tick(HOLD);
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        tick(HOLD);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_ena",     ena, 1);
        check_val("rst_wea",     {wea_c, wea_b, wea_a}, 0);
        check_val("rst_addra",   addra, 0);
        check_val("rst_dina",    dina, 0);
        check_val("rst_sel",     operand_sel, OP_A);
        check_val("rst_loading", loading, 1);
        check_val("rst_done",    done, 0);
    endtask

    // Write monitor: every strobe must be one-hot, single-cycle and match the scoreboard
    always @(negedge clock_100Mhz) begin
        mon_w = {wea_c, wea_b, wea_a};
        if (!reset && mon_w != 3'b000) begin
            n_strobes++;
            check_val("strobe_onehot", $countones(mon_w), 1);
            check_val("strobe_width", prev_w, 0);
            if (sb.size() == 0) begin
                check_val("unexpected_strobe", mon_w, 0);
            end else begin
                mon_e = sb.pop_front();
                exp_w = 3'b001 << mon_e.sel;
                check_val("wr_target", mon_w, exp_w);
                check_val("wr_addr", addra, mon_e.addr);
                check_val("wr_data", dina, mon_e.data);
                check_val("sel_during_write", operand_sel, mon_e.sel);
            end
        end
        prev_w = mon_w;
    end

    initial begin
        repeat (20000) @(posedge clock_100Mhz);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset
        tick(3);
        check_reset_outputs();
        reset = 1'b0;
        tick(3);
        check_val("idle_sel", operand_sel, OP_A);

        // Bounce rejection: toggling every 2 cycles never settles, then a clean hold
        expect_wr(OP_A, 0, 18'h01234);
        sw = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            btn_load = ~btn_load;
            tick(2);
        end
        btn_load = 1'b1;
        tick(10);
        btn_load = 1'b0;
        tick(HOLD);
        check_val("bounce_sel", operand_sel, OP_B);
        check_val("bounce_addr", addra, 0);

        // Reset mid-run abandons the partial row
        @(negedge clock_100Mhz);
        reset = 1'b1;
        tick(2);
        check_reset_outputs();
        reset = 1'b0;
        tick(3);

        // Full load of two rows
        expect_wr(OP_A, 0, 18'd1);
        expect_wr(OP_B, 0, 18'd2);
        expect_wr(OP_C, 0, 18'd3);
        expect_wr(OP_A, 1, 18'd4);
        expect_wr(OP_B, 1, 18'd5);
        expect_wr(OP_C, 1, 18'd6);
        press(1'b1, 1'b0, 16'd1);
        press(1'b1, 1'b0, 16'd2);
        press(1'b1, 1'b0, 16'd3);
        check_val("row1_addr", addra, 1);
        check_val("row1_sel", operand_sel, OP_A);
        check_val("row1_done", done, 0);
        press(1'b1, 1'b0, 16'd4);
        press(1'b1, 1'b0, 16'd5);
        press(1'b1, 1'b0, 16'd6);
        check_val("full_done", done, 1);
        check_val("full_loading", loading, 0);
        check_val("full_sel", operand_sel, OP_NONE);
        check_val("full_addr", addra, 0);

        // DONE lockout: a further press writes nothing
        press(1'b1, 1'b0, 16'd7);
        check_val("lock_done", done, 1);
        check_val("lock_sel", operand_sel, OP_NONE);
        check_val("lock_addr", addra, 0);

        // Clear out of DONE
        press(1'b0, 1'b1, 16'd0);
        check_val("clr_done", done, 0);
        check_val("clr_loading", loading, 1);
        check_val("clr_sel", operand_sel, OP_A);

        // Clear mid-entry after A[0], B[0]
        expect_wr(OP_A, 0, 18'h00011);
        expect_wr(OP_B, 0, 18'h00022);
        press(1'b1, 1'b0, 16'h0011);
        press(1'b1, 1'b0, 16'h0022);
        check_val("mid_sel", operand_sel, OP_C);
        press(1'b0, 1'b1, 16'h0000);
        check_val("mid_clr_addr", addra, 0);
        check_val("mid_clr_sel", operand_sel, OP_A);
        check_val("mid_clr_done", done, 0);
        check_val("mid_clr_dina", dina, 0);
        expect_wr(OP_A, 0, 18'h00033);
        press(1'b1, 1'b0, 16'h0033);
        check_val("rewrite_sel", operand_sel, OP_B);

        // Simultaneous clear and load: clear wins, nothing written
        press(1'b1, 1'b1, 16'h0044);
        check_val("both_sel", operand_sel, OP_A);
        check_val("both_addr", addra, 0);
        check_val("both_dina", dina, 0);

        tick(4);
        check_val("strobe_count", n_strobes, 10);
        check_val("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_bram_loader.md
Name: operand_bram_loader

Overview:
- Writer side of the operand BRAMs (A, B, C; 18-bit wide, 8 deep) that the display/DSP datapath reads.
- Operator sets 16 switches and presses a load button. Each press writes one operand word, in order A, B, C, into the current address.
- The address then advances, up to DEPTH entries.
- Signals `loading`/`done` so the reader side holds off until the tables are full.

Parameters:
- DATA_W, 18, BRAM word width; switch value is zero-extended to this width.
- ADDR_W, 3, BRAM address width.
- DEPTH, 8, number of entries loaded per operand (must be ≤ 2**ADDR_W).
- DEBOUNCE_CYCLES, 1000000, clock cycles a button must be stable to be accepted (10 ms at 100 MHz).

Ports:
- clock_100Mhz  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- sw  in  16  raw operand switches (asynchronous to the clock).
- btn_load  in  1  raw load push-button (asynchronous, bouncy).
- btn_clear  in  1  raw restart push-button (asynchronous, bouncy).
- ena  out  1  BRAM port enable.
- wea_a  out  1  write strobe, BRAM A.
- wea_b  out  1  write strobe, BRAM B.
- wea_c  out  1  write strobe, BRAM C.
- addra  out  ADDR_W  shared BRAM address.
- dina  out  DATA_W  shared BRAM write data.
- operand_sel  out  2  operand awaiting entry: 0=A, 1=B, 2=C, 3=none (done).
- loading  out  1  high while the table is incomplete; reader must not sample.
- done  out  1  high once all DEPTH×3 words are written.

Behaviour:
- Reset state (all outputs): ena=1, wea_*=0, addra=0, dina=0, operand_sel=0, loading=1, done=0. FSM enters WAIT_A.
- Input conditioning:
  - Each button passes through a 2-FF synchronizer, then the debouncer.
  - The debounced level changes only after the synchronized input has held the new value for DEBOUNCE_CYCLES consecutive cycles.
  - The loader acts on a one-cycle pulse at the debounced rising edge. Release edges are ignored.
  - sw is 2-FF synchronized and sampled in the press-pulse cycle.
- FSM states: WAIT_A, WAIT_B, WAIT_C, WRITE, DONE.
  - WAIT_x + load pulse: capture dina={zeros, sw_sync}, assert wea_x only. Go to WRITE with a remembered target x.
  - WRITE lasts exactly one cycle:
    - Deassert all wea_*.
    - If target A → WAIT_B; if B → WAIT_C.
    - If C and addra < DEPTH-1 → addra+1, WAIT_A.
    - If C and addra == DEPTH-1 → DONE.
  - Exactly one wea_* is high at any time, for exactly one cycle per accepted press.
  - addra and dina are stable during the strobe cycle.
- DONE: done=1, loading=0, operand_sel=3, addra=0 (ready for the reader). Load pulses are ignored.
- Clear pulse, in any state: next cycle addra=0, dina=0, wea_*=0, done=0, loading=1, go to WAIT_A. Previously written BRAM contents are not erased.
- Boundary cases:
  - Clear and load pulses in the same cycle: clear wins, nothing is written.
  - Load pulse during WRITE: cannot occur, since pulses are ≥ DEBOUNCE_CYCLES apart.
  - Defensively, the pulse is dropped if it does occur.
  - Reset mid-write: the strobe drops immediately (asynchronous); the partial table is abandoned.
- operand_sel = 0/1/2 while in WAIT_A/B/C. During WRITE it holds the value of the preceding WAIT state.
- Latency: button held stable → strobe after 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.

Decomposition:
- Shared package: operand-select encodings (OP_A=0, OP_B=1, OP_C=2, OP_NONE=3) and FSM state encodings, so the reader and any status logic can decode operand_sel.
- One natural sub-module: `button_debouncer`. It contains the 2-FF synchronizer, the stability counter (parameter DEBOUNCE_CYCLES) and rising-edge pulse generation, and is instantiated twice. The switch synchronizer stays inline.

Test Plan (bench uses DEBOUNCE_CYCLES=4, DEPTH=2):
- Reset: assert reset mid-run → all outputs at reset values; addra=0, operand_sel=0, loading=1.
- Bounce rejection: btn_load toggles every 2 cycles for 20 cycles, then holds high for 10 cycles → exactly one wea_a pulse; dina=0x01234 with sw=16'h1234.
- Full load: six clean presses with sw=1,2,3,4,5,6 → writes A[0]=1, B[0]=2, C[0]=3, A[1]=4, B[1]=5, C[1]=6. One-hot single-cycle strobes; then done=1, loading=0, operand_sel=3, addra=0.
- DONE lockout: extra press after done → no wea_* activity, state unchanged.
- Clear mid-entry: after writing A[0] and B[0], press clear → addra=0, operand_sel=0, done=0. The next press writes A[0] again.
- Simultaneous clear+load: both debounced edges in the same cycle → no strobe; FSM in WAIT_A, addra=0.
